// File: rtl/morse_defs_pkg.sv
// Shared Morse definitions: letter codes, symbol encoding, buffer limits,
// decoder FSM states and the pattern-lookup result payload.
package morse_defs;

  localparam int unsigned LETTER_W    = 3;
  localparam int unsigned SYM_W       = 4;
  localparam int unsigned SYM_CNT_W   = 3;
  localparam int unsigned RUN_CNT_W   = 3;
  localparam int unsigned MAX_SYMS    = 4;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam logic [LETTER_W-1:0] LTR_I = 3'd0;
  localparam logic [LETTER_W-1:0] LTR_J = 3'd1;
  localparam logic [LETTER_W-1:0] LTR_K = 3'd2;
  localparam logic [LETTER_W-1:0] LTR_L = 3'd3;
  localparam logic [LETTER_W-1:0] LTR_M = 3'd4;
  localparam logic [LETTER_W-1:0] LTR_N = 3'd5;
  localparam logic [LETTER_W-1:0] LTR_O = 3'd6;
  localparam logic [LETTER_W-1:0] LTR_P = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  typedef struct packed {
    logic                hit;
    logic [LETTER_W-1:0] code;
  } lut_out_t;

endpackage

// File: rtl/morse_pattern_lut.sv
// Combinational map from a collected symbol buffer to a letter code.
// Ports:
//   sym_cnt  number of valid symbols (0..4)
//   sym      symbols, first received in bit 0 (DOT=0, DASH=1)
//   lut_c    {hit, code}; hit=0 when the pattern is not a known letter
module morse_pattern_lut
  import morse_defs::*;
(
  input  logic [SYM_CNT_W-1:0] sym_cnt,
  input  logic [SYM_W-1:0]     sym,
  output lut_out_t             lut_c
);

  logic [SYM_W-1:0] mask;
  logic [SYM_W-1:0] sym_m;

  // Ignore buffer bits beyond the valid symbol count.
  always_comb begin
    mask = 4'b0000;
    case (sym_cnt)
      3'd1:    mask = 4'b0001;
      3'd2:    mask = 4'b0011;
      3'd3:    mask = 4'b0111;
      3'd4:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    sym_m = sym & mask;
  end

  // Patterns are written with the first symbol in the LSB.
  always_comb begin
    lut_c.hit  = 1'b1;
    lut_c.code = LTR_I;
    case ({sym_cnt, sym_m})
      {3'd2, 4'b0000}: lut_c.code = LTR_I;  // ..
      {3'd4, 4'b1110}: lut_c.code = LTR_J;  // .---
      {3'd3, 4'b0101}: lut_c.code = LTR_K;  // -.-
      {3'd4, 4'b0010}: lut_c.code = LTR_L;  // .-..
      {3'd2, 4'b0011}: lut_c.code = LTR_M;  // --
      {3'd2, 4'b0001}: lut_c.code = LTR_N;  // -.
      {3'd3, 4'b0111}: lut_c.code = LTR_O;  // ---
      {3'd4, 4'b0110}: lut_c.code = LTR_P;  // .--.
      default:         lut_c.hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_letter_decoder.sv
// Decodes a tick-sampled Morse LED stream back into 3-bit letter codes.
// Ports:
//   clk, Reset_b   clock and asynchronous active-low reset
//   tick           sample enable; all state advances only when high
//   bit_in         serial stream, 1 = LED on
//   letter         last legally decoded letter, held between decodes
//   letter_valid   one-clk pulse when letter is updated
//   letter_err     one-clk pulse when a letter ended malformed/unknown
//   busy           high while a letter is in progress
module morse_letter_decoder
  import morse_defs::*;
#(
  parameter int unsigned DASH_TICKS = 3,
  parameter int unsigned GAP_TICKS  = 3
) (
  input  logic                clk,
  input  logic                Reset_b,
  input  logic                tick,
  input  logic                bit_in,
  output logic [LETTER_W-1:0] letter,
  output logic                letter_valid,
  output logic                letter_err,
  output logic                busy
);

  state_t                state, state_nxt;
  logic [RUN_CNT_W-1:0]  mark_cnt, mark_cnt_nxt;
  logic [RUN_CNT_W-1:0]  space_cnt, space_cnt_nxt;
  logic [SYM_W-1:0]      sym, sym_nxt;
  logic [SYM_CNT_W-1:0]  sym_cnt, sym_cnt_nxt;
  logic                  err, err_nxt;
  logic [LETTER_W-1:0]   letter_nxt;
  logic                  letter_valid_nxt;
  logic                  letter_err_nxt;
  logic                  busy_nxt;
  logic [RUN_CNT_W-1:0]  space_inc;
  lut_out_t              lut_c;

  morse_pattern_lut u_lut (
    .sym_cnt (sym_cnt),
    .sym     (sym),
    .lut_c   (lut_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge Reset_b) begin
    if (!Reset_b) begin
      state        <= ST_IDLE;
      mark_cnt     <= '0;
      space_cnt    <= '0;
      sym          <= '0;
      sym_cnt      <= '0;
      err          <= 1'b0;
      letter       <= '0;
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      mark_cnt     <= mark_cnt_nxt;
      space_cnt    <= space_cnt_nxt;
      sym          <= sym_nxt;
      sym_cnt      <= sym_cnt_nxt;
      err          <= err_nxt;
      letter       <= letter_nxt;
      letter_valid <= letter_valid_nxt;
      letter_err   <= letter_err_nxt;
      busy         <= busy_nxt;
    end
  end

  assign space_inc = space_cnt + 3'd1;

  // Next-state, run counting, symbol classification and letter decode.
  always_comb begin
    state_nxt        = state;
    mark_cnt_nxt     = mark_cnt;
    space_cnt_nxt    = space_cnt;
    sym_nxt          = sym;
    sym_cnt_nxt      = sym_cnt;
    err_nxt          = err;
    letter_nxt       = letter;
    letter_valid_nxt = 1'b0;
    letter_err_nxt   = 1'b0;

    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (bit_in) begin
            mark_cnt_nxt = 3'd1;
            state_nxt    = ST_MARK;
          end
        end

        ST_MARK: begin
          if (bit_in) begin
            if (mark_cnt != 3'd7) mark_cnt_nxt = mark_cnt + 3'd1;
          end else begin
            // Bad lengths are flagged and still stored as a dot so sym_cnt tracks every mark.
            if (mark_cnt != 3'd1 && mark_cnt != RUN_CNT_W'(DASH_TICKS)) err_nxt = 1'b1;
            if (sym_cnt == SYM_CNT_W'(MAX_SYMS)) begin
              err_nxt = 1'b1;
            end else begin
              sym_nxt[sym_cnt[1:0]] = (mark_cnt == RUN_CNT_W'(DASH_TICKS)) ? DASH : DOT;
              sym_cnt_nxt           = sym_cnt + 3'd1;
            end
            space_cnt_nxt = 3'd1;
            state_nxt     = ST_SPACE;
          end
        end

        ST_SPACE: begin
          if (bit_in) begin
            mark_cnt_nxt = 3'd1;
            state_nxt    = ST_MARK;
          end else begin
            space_cnt_nxt = space_inc;
            if (space_inc == RUN_CNT_W'(GAP_TICKS)) begin
              if (err || !lut_c.hit) begin
                letter_err_nxt = 1'b1;
              end else begin
                letter_nxt       = lut_c.code;
                letter_valid_nxt = 1'b1;
              end
              sym_nxt     = '0;
              sym_cnt_nxt = '0;
              err_nxt     = 1'b0;
              state_nxt   = ST_IDLE;
            end
          end
        end

        default: state_nxt = ST_IDLE;
      endcase
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule
